// File: rtl/sram_pkg.sv
// Shared types and constants for the background-loader SRAM read path.
package sram_pkg;

    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } sram_state_e;

    // {CE_N, OE_N, UB_N, LB_N} when the SRAM is not being accessed
    localparam logic [3:0] SRAM_PINS_IDLE = 4'b1111;

endpackage

// File: rtl/sram_bg_reader.sv
// Read-only SRAM controller: 4-phase request from the background loader, fixed-wait read, one-cycle done pulse.
// Optional macro SRAM_BG_BYTE_SWAP_EN swaps the two bytes of each captured word (little-endian images).
module sram_bg_reader
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   reading,
    input  logic [SRAM_ADDR_W-1:0] ADDR,
    output logic                   SRAM_done,
    output logic [SRAM_DATA_W-1:0] DATA_IN,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N,
    input  logic [SRAM_DATA_W-1:0] SRAM_DQ
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("sram_bg_reader: WAIT_CYCLES must be in 1..15");
    end

    sram_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             pins_q, pins_d;
    logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
    logic [SRAM_DATA_W-1:0] data_q, data_d;
    logic                   done_q, done_d;

    function automatic logic [SRAM_DATA_W-1:0] capture_word(input logic [SRAM_DATA_W-1:0] dq);
`ifdef SRAM_BG_BYTE_SWAP_EN
        return {dq[7:0], dq[15:8]};
`else
        return dq;
`endif
    endfunction

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pins_q  <= SRAM_PINS_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pins_q  <= pins_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (reading) state_d = ACCESS;
            ACCESS:  if (cnt_q == '0) state_d = ACK;
            // A request held high stays parked here so it is never read twice
            ACK:     if (!reading) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        pins_d = pins_q;
        addr_d = addr_q;
        data_d = data_q;
        done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (reading) begin
                    addr_d = ADDR;
                    pins_d = 4'b0000;
                    cnt_d  = CNT_LOAD;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    data_d = capture_word(SRAM_DQ);
                    done_d = 1'b1;
                    pins_d = SRAM_PINS_IDLE;
                end
            end
            ACK: begin
                pins_d = SRAM_PINS_IDLE;
            end
            default: begin
                pins_d = SRAM_PINS_IDLE;
            end
        endcase
    end

    assign SRAM_done = done_q;
    assign DATA_IN   = data_q;
    assign SRAM_ADDR = addr_q;
    assign SRAM_CE_N = pins_q[3];
    assign SRAM_OE_N = pins_q[2];
    assign SRAM_UB_N = pins_q[1];
    assign SRAM_LB_N = pins_q[0];
    assign SRAM_WE_N = 1'b1;

endmodule

// File: tb/tb_sram_bg_reader.sv
// Directed bench for sram_bg_reader (WAIT_CYCLES=2) with a small combinational SRAM model.
module tb_sram_bg_reader;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        reading;
    logic [19:0] ADDR;
    logic        SRAM_done;
    logic [15:0] DATA_IN;
    logic [19:0] SRAM_ADDR;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
    logic [15:0] SRAM_DQ;
    logic [15:0] mem_word;

    int n_checks = 0;
    int n_errors = 0;

    sram_bg_reader #(.WAIT_CYCLES(2)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .reading   (reading),
        .ADDR      (ADDR),
        .SRAM_done (SRAM_done),
        .DATA_IN   (DATA_IN),
        .SRAM_ADDR (SRAM_ADDR),
        .SRAM_CE_N (SRAM_CE_N),
        .SRAM_OE_N (SRAM_OE_N),
        .SRAM_WE_N (SRAM_WE_N),
        .SRAM_UB_N (SRAM_UB_N),
        .SRAM_LB_N (SRAM_LB_N),
        .SRAM_DQ   (SRAM_DQ)
    );

    always #5 Clk = ~Clk;

    always_comb begin
        mem_word = 16'h5A5A;
        case (SRAM_ADDR)
            20'h00000: mem_word = 16'h0101;
            20'h00001: mem_word = 16'h0202;
            20'h00002: mem_word = 16'hFFFF;
            20'h00003: mem_word = 16'hABCD;
            20'h25801: mem_word = 16'h1234;
            default:   mem_word = 16'h5A5A;
        endcase
    end
    assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N) ? mem_word : 16'h0000;

    function automatic logic [15:0] exp_word(input logic [15:0] w);
`ifdef SRAM_BG_BYTE_SWAP_EN
        return {w[7:0], w[15:8]};
`else
        return w;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_done(input int max_cycles, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!SRAM_done && cycles < max_cycles);
        chk("done_seen", {31'd0, SRAM_done}, 32'd1);
    endtask

    initial begin
        int cyc;
        int n_done;
        int n_acc;
        logic [15:0] stream_data [3];
        stream_data[0] = 16'h0101;
        stream_data[1] = 16'h0202;
        stream_data[2] = 16'hFFFF;

        Reset_n = 1'b0;
        reading = 1'b0;
        ADDR    = '0;
        repeat (3) tick();
        chk("rst_pins", {28'd0, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N}, 32'hF);
        chk("rst_we", {31'd0, SRAM_WE_N}, 32'd1);
        chk("rst_done", {31'd0, SRAM_done}, 32'd0);
        chk("rst_data", {16'd0, DATA_IN}, 32'd0);
        chk("rst_addr", {12'd0, SRAM_ADDR}, 32'd0);
        Reset_n = 1'b1;
        tick();

        // Single read; request then held high to exercise ACK parking
        reading = 1'b1;
        ADDR    = 20'h25801;
        tick();
        chk("e0_addr", {12'd0, SRAM_ADDR}, 32'h25801);
        chk("e0_pins", {28'd0, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N}, 32'h0);
        chk("e0_done", {31'd0, SRAM_done}, 32'd0);
        ADDR = 20'h00003;
        tick();
        chk("e1_done", {31'd0, SRAM_done}, 32'd0);
        chk("e1_addr_hold", {12'd0, SRAM_ADDR}, 32'h25801);
        tick();
        chk("e2_done", {31'd0, SRAM_done}, 32'd1);
        chk("e2_data", {16'd0, DATA_IN}, {16'd0, exp_word(16'h1234)});
        chk("e2_pins", {28'd0, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N}, 32'hF);

        n_done = 0;
        n_acc  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (SRAM_done) n_done++;
            if (!SRAM_CE_N) n_acc++;
        end
        chk("held_extra_done", n_done, 0);
        chk("held_extra_access", n_acc, 0);
        chk("held_data", {16'd0, DATA_IN}, {16'd0, exp_word(16'h1234)});
        reading = 1'b0;
        tick();
        chk("held_idle_pins", {31'd0, SRAM_CE_N}, 32'd1);

        // Loader-pattern stream
        for (int w = 0; w < 3; w++) begin
            reading = 1'b1;
            ADDR    = 20'(w);
            wait_done(10, cyc);
            if (w > 0) chk($sformatf("stream_gap%0d", w), cyc + 1, 4);
            else       chk("stream_lat0", cyc, 3);
            chk($sformatf("stream_addr%0d", w), {12'd0, SRAM_ADDR}, w);
            chk($sformatf("stream_data%0d", w), {16'd0, DATA_IN}, {16'd0, exp_word(stream_data[w])});
            reading = 1'b0;
            tick();
            chk($sformatf("stream_pulse%0d", w), {31'd0, SRAM_done}, 32'd0);
        end

        // Async reset mid-access
        reading = 1'b1;
        ADDR    = 20'h00005;
        tick();
        chk("ar_e0_ce", {31'd0, SRAM_CE_N}, 32'd0);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("ar_pins", {28'd0, SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N}, 32'hF);
        chk("ar_addr", {12'd0, SRAM_ADDR}, 32'd0);
        reading = 1'b0;
        Reset_n = 1'b1;
        n_done = 0;
        n_acc  = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (SRAM_done) n_done++;
            if (!SRAM_CE_N) n_acc++;
        end
        chk("ar_no_done", n_done, 0);
        chk("ar_idle", n_acc, 0);
        chk("ar_data", {16'd0, DATA_IN}, 32'd0);

        // Byte-order read (swapped only when the macro is defined)
        reading = 1'b1;
        ADDR    = 20'h00003;
        wait_done(10, cyc);
        chk("swap_lat", cyc, 3);
        chk("swap_data", {16'd0, DATA_IN}, {16'd0, exp_word(16'hABCD)});
        reading = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_bg_reader.md
Name: sram_bg_reader

Overview:
- Read-only SRAM access controller feeding the background loader.
- Accepts a 4-phase read request (reading + ADDR) from load_background, drives the external 16-bit SRAM pins, waits a fixed access time and captures the word.
- Returns the word on a registered data bus with a one-cycle SRAM_done pulse.
- Sits between the loader and the board SRAM pins; the write side is out of scope.

Parameters:
- WAIT_CYCLES, 2: number of clock cycles CE_N/OE_N are held low before DQ is sampled; legal range 1..15; 0 is an elaboration error.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- reading  in  1  read request level from loader
- ADDR  in  20  word address, sampled when a request is accepted
- SRAM_done  out  1  one-cycle pulse: DATA_IN is valid
- DATA_IN  out  16  captured read word, registered, held until next capture
- SRAM_ADDR  out  20  address pins, registered
- SRAM_CE_N  out  1  chip enable, active low
- SRAM_OE_N  out  1  output enable, active low
- SRAM_WE_N  out  1  write enable; constant 1
- SRAM_UB_N  out  1  upper byte enable, active low
- SRAM_LB_N  out  1  lower byte enable, active low
- SRAM_DQ  in  16  data pins (read only)

Behaviour:
- All outputs are registered except SRAM_WE_N, which is tied to 1.
- Reset (Reset_n=0, asynchronous, any state):
  - state=IDLE, SRAM_done=0, DATA_IN=0, SRAM_ADDR=0.
  - CE_N, OE_N, UB_N and LB_N are all 1.
  - Wait counter=0.
  - An access in flight is abandoned with no done pulse.
- States are IDLE, ACCESS and ACK.
- IDLE:
  - Pins are inactive.
  - At an edge with reading=1: SRAM_ADDR<=ADDR, CE_N/OE_N/UB_N/LB_N<=0, counter<=WAIT_CYCLES-1, go to ACCESS.
- ACCESS:
  - Pins stay active and ADDR changes are ignored.
  - Counter>0: decrement.
  - Counter==0 at an edge: DATA_IN<=SRAM_DQ, SRAM_done<=1, pins<=inactive, go to ACK.
- ACK:
  - SRAM_done returns to 0 after exactly one cycle, regardless of reading.
  - Leave to IDLE only at an edge where reading=0.
  - If reading stays 1, remain in ACK and never re-read the same request.
- Latency: request accepted at edge E0; SRAM_done is high during the cycle after edge E(WAIT_CYCLES).
- Throughput: best case one word per WAIT_CYCLES+2 cycles (WAIT_CYCLES+1 edges to done, plus one edge for reading low in ACK).
  - The loader drops reading for exactly one cycle in its write state, which satisfies this.
- reading deasserted mid-ACCESS:
  - The access still completes and SRAM_done still pulses.
  - The ACK state then exits on the next edge.
- DATA_IN is stable from capture until the next capture.
  - The loader's end-marker compare (>16'hF000) therefore sees the previous word while a new access is pending.
- SRAM_ADDR holds the last accepted address while idle; only the enables return to 1.

Optional Feature:
- Macro: SRAM_BG_BYTE_SWAP_EN.
- Defined: the capture stores {SRAM_DQ[7:0], SRAM_DQ[15:8]}, for background images stored little-endian.
- Undefined: SRAM_DQ is stored unchanged.
- Timing and handshake are identical either way.

Decomposition:
- Package sram_pkg holds:
  - SRAM_ADDR_W=20 and SRAM_DATA_W=16.
  - The state enum {IDLE, ACCESS, ACK} as logic [1:0].
  - Constant SRAM_PINS_IDLE (the CE/OE/UB/LB idle value, 4'b1111).
- No sub-module; the wait counter is inline, width $clog2(WAIT_CYCLES+1).

Test Plan:
- Reset: hold Reset_n=0, then release. Required: all enables=1, WE_N=1, SRAM_done=0, DATA_IN=0.
- Single read (WAIT_CYCLES=2): reading=1 with ADDR=20'h25801 and SRAM model returning 16'h1234. Required: SRAM_ADDR=20'h25801 and CE_N=OE_N=0 after E0; SRAM_done=1 for one cycle after E2; DATA_IN=16'h1234; enables=1.
- Held request: keep reading=1 for 10 cycles after done. Required: exactly one done pulse and one access; state stays ACK; the next access starts only after reading drops for one cycle.
- Loader-pattern stream: 3 words 16'h0101, 16'h0202, 16'hFFFF at addresses 0..2, with reading dropped for one cycle after each done. Required: three done pulses, consecutive SRAM_ADDR 0, 1, 2, DATA_IN sequence matches, 4 cycles between pulses.
- Async reset mid-ACCESS: pulse Reset_n low between E0 and E2. Required: immediate pin release (enables=1) with no clock edge; no done pulse; clean IDLE.
- SRAM_BG_BYTE_SWAP_EN defined: SRAM returns 16'hABCD. Required: DATA_IN=16'hCDAB with latency unchanged.
